// File: rtl/baccarat_fsm.sv
// Baccarat hand controller: sequences the six card-load strobes, applies the
// natural / player / banker drawing rules and latches the win lights.
// Define BACCARAT_FSM_DEBUG_EN to expose state_out and enable the dwell checker.
module baccarat_fsm (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light
`ifdef BACCARAT_FSM_DEBUG_EN
    ,
    output logic [3:0] state_out
`endif
);

    typedef enum logic [3:0] {
        S_START = 4'd0,
        S_P1    = 4'd1,
        S_D1    = 4'd2,
        S_P2    = 4'd3,
        S_D2    = 4'd4,
        S_CHK   = 4'd5,
        S_P3    = 4'd6,
        S_CHK3  = 4'd7,
        S_D3    = 4'd8,
        S_SCORE = 4'd9,
        S_DONE  = 4'd10
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] load_d;
    logic       pwin_d, dwin_d;

    // Scores of 10 or more never count as a natural.
    function automatic logic is_natural(input logic [3:0] s);
        return (s == 4'd8) || (s == 4'd9);
    endfunction

    // Face cards (J/Q/K) contribute 0 to the banker decision.
    function automatic logic banker_draws(input logic [3:0] d, input logic [3:0] c3);
        logic [3:0] v;
        v = (c3 <= 4'd9) ? c3 : 4'd0;
        case (d)
            4'd0, 4'd1, 4'd2: return 1'b1;
            4'd3:             return v != 4'd8;
            4'd4:             return (v >= 4'd2) && (v <= 4'd7);
            4'd5:             return (v >= 4'd4) && (v <= 4'd7);
            4'd6:             return (v >= 4'd6) && (v <= 4'd7);
            default:          return 1'b0;
        endcase
    endfunction

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q          <= S_START;
            load_pcard1      <= 1'b0;
            load_dcard1      <= 1'b0;
            load_pcard2      <= 1'b0;
            load_dcard2      <= 1'b0;
            load_pcard3      <= 1'b0;
            load_dcard3      <= 1'b0;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else begin
            state_q          <= state_d;
            load_pcard1      <= load_d[0];
            load_dcard1      <= load_d[1];
            load_pcard2      <= load_d[2];
            load_dcard2      <= load_d[3];
            load_pcard3      <= load_d[4];
            load_dcard3      <= load_d[5];
            player_win_light <= pwin_d;
            dealer_win_light <= dwin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START: state_d = S_P1;
            S_P1:    state_d = S_D1;
            S_D1:    state_d = S_P2;
            S_P2:    state_d = S_D2;
            S_D2:    state_d = S_CHK;
            S_CHK: begin
                if (is_natural(pscore) || is_natural(dscore)) state_d = S_DONE;
                else if (pscore <= 4'd5)                      state_d = S_P3;
                else if (dscore <= 4'd5)                      state_d = S_D3;
                else                                          state_d = S_DONE;
            end
            S_P3:    state_d = S_CHK3;
            S_CHK3:  state_d = banker_draws(dscore, pcard3) ? S_D3 : S_DONE;
            S_D3:    state_d = S_SCORE;
            S_SCORE: state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_START;
        endcase
    end

    // Outputs are decoded from the next state so the registered strobes line up with their state.
    always_comb begin
        load_d = 6'b0;
        case (state_d)
            S_P1:    load_d[0] = 1'b1;
            S_D1:    load_d[1] = 1'b1;
            S_P2:    load_d[2] = 1'b1;
            S_D2:    load_d[3] = 1'b1;
            S_P3:    load_d[4] = 1'b1;
            S_D3:    load_d[5] = 1'b1;
            default: load_d = 6'b0;
        endcase
        pwin_d = player_win_light;
        dwin_d = dealer_win_light;
        if (state_q != S_DONE && state_d == S_DONE) begin
            pwin_d = pscore >= dscore;
            dwin_d = dscore >= pscore;
        end
    end

`ifdef BACCARAT_FSM_DEBUG_EN
    logic [3:0] cyc_cnt;

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'd15) ? c : c + 4'd1;
    endfunction

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb)                cyc_cnt <= 4'd0;
        else if (state_d != state_q) cyc_cnt <= 4'd0;
        else                        cyc_cnt <= sat_inc(cyc_cnt);
    end

    // Every state except S_DONE is transient; a repeat means the sequencing broke.
    always_ff @(posedge slow_clock) begin
        if (resetb && state_q != S_DONE && cyc_cnt != 4'd0)
            $error("baccarat_fsm: state %0d held for %0d extra cycles", state_q, cyc_cnt);
    end

    assign state_out = state_q;
`endif

endmodule

// File: tb/tb_baccarat_fsm.sv
// Directed bench for baccarat_fsm: a stand-in datapath reacts to the strobes
// and a rule-level model predicts strobe timing and lights for each hand.
module tb_baccarat_fsm;

    logic       slow_clock = 1'b0;
    logic       resetb = 1'b0;
    logic [3:0] pscore = 4'd0, dscore = 4'd0, pcard3 = 4'd0;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;
`ifdef BACCARAT_FSM_DEBUG_EN
    logic [3:0] state_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 slow_clock = ~slow_clock;

    baccarat_fsm dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light)
`ifdef BACCARAT_FSM_DEBUG_EN
        ,
        .state_out        (state_out)
`endif
    );

    // p0/d0: two-card scores; c3: player third card; pf/df: scores after third cards.
    // le/pw/dw: hand-computed light edge and light values.
    typedef struct {
        int p0; int d0; int c3; int pf; int df;
        int le; int pw; int dw;
    } hand_t;

    hand_t hands[9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Banker drawing table: bit v of the entry for dscore d is set when the banker draws.
    function automatic bit banker_rule(input int d, input int v);
        bit [9:0] draw_mask [0:9];
        draw_mask = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF, 10'h0FC,
                      10'h0F0, 10'h0C0, 10'h000, 10'h000, 10'h000};
        if (d > 9) return 1'b0;
        return draw_mask[d][v];
    endfunction

    task automatic model(input hand_t h, output int p3_edge, output int d3_edge,
                         output int light_edge, output bit pw, output bit dw);
        bit natural, pdraw, bdraw;
        int v, pf, df;
        natural = (h.p0 == 8 || h.p0 == 9 || h.d0 == 8 || h.d0 == 9);
        pdraw   = !natural && h.p0 <= 5;
        v       = (h.c3 <= 9) ? h.c3 : 0;
        if (natural)    bdraw = 1'b0;
        else if (pdraw) bdraw = banker_rule(h.d0, v);
        else            bdraw = h.d0 <= 5;
        p3_edge    = pdraw ? 6 : -1;
        d3_edge    = bdraw ? (pdraw ? 8 : 6) : -1;
        light_edge = 6 + 2 * (int'(pdraw) + int'(bdraw));
        pf = pdraw ? h.pf : h.p0;
        df = bdraw ? h.df : h.d0;
        pw = pf >= df;
        dw = df >= pf;
    endtask

    function automatic logic [7:0] all_outputs();
        return {load_dcard3, load_pcard3, load_dcard2, load_pcard2,
                load_dcard1, load_pcard1, player_win_light, dealer_win_light};
    endfunction

    task automatic run_hand(input int idx);
        hand_t h;
        int p3_edge, d3_edge, light_edge;
        bit pw, dw, pend_p, pend_d;
        logic [5:0] act_s, exp_s;
        h = hands[idx];
        model(h, p3_edge, d3_edge, light_edge, pw, dw);
        check($sformatf("h%0d_model_light_edge", idx), 8'(light_edge), 8'(h.le));
        check($sformatf("h%0d_model_lights", idx), {6'd0, pw, dw}, 8'({h.pw[0], h.dw[0]}));

        resetb = 1'b0;
        pscore = 4'(h.p0);
        dscore = 4'(h.d0);
        pcard3 = 4'd0;
        repeat (2) @(posedge slow_clock);
        #1;
        check($sformatf("h%0d_reset_outputs", idx), all_outputs(), 8'd0);
        @(negedge slow_clock);
        resetb = 1'b1;
        pend_p = 1'b0;
        pend_d = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge slow_clock);
            #1;
            if (pend_p) begin
                pcard3 = 4'(h.c3);
                pscore = 4'(h.pf);
                pend_p = 1'b0;
            end
            if (pend_d) begin
                dscore = 4'(h.df);
                pend_d = 1'b0;
            end
            exp_s = {e == d3_edge, e == p3_edge, e == 4, e == 3, e == 2, e == 1};
            act_s = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
            check($sformatf("h%0d_e%0d_strobes", idx, e), 8'(act_s), 8'(exp_s));
            check($sformatf("h%0d_e%0d_onehot", idx, e), ($countones(act_s) <= 1) ? 8'd1 : 8'd0, 8'd1);
            check($sformatf("h%0d_e%0d_lights", idx, e), {6'd0, player_win_light, dealer_win_light},
                  (e >= light_edge) ? {6'd0, pw, dw} : 8'd0);
            if (load_pcard3) pend_p = 1'b1;
            if (load_dcard3) pend_d = 1'b1;
        end
    endtask

    initial begin
        //               p0 d0 c3  pf df  le pw dw
        hands[0] = '{8, 3, 0,  8, 3,  6, 1, 0};  // natural
        hands[1] = '{4, 7, 5,  9, 7,  8, 1, 0};  // player draws, banker stands
        hands[2] = '{3, 6, 6,  9, 8, 10, 1, 0};  // dscore 6, v 6: banker draws
        hands[3] = '{3, 6, 12, 3, 0,  8, 0, 1};  // queen counts 0: banker stands
        hands[4] = '{7, 5, 0,  7, 7,  8, 1, 1};  // player stands, banker draws, tie
        hands[5] = '{6, 6, 0,  6, 6,  6, 1, 1};  // both stand, tie
        hands[6] = '{2, 9, 0,  2, 9,  6, 0, 1};  // dealer natural
        hands[7] = '{5, 3, 8,  3, 3,  8, 1, 1};  // dscore 3 vs an 8: stand
        hands[8] = '{0, 4, 7,  7, 9, 10, 0, 1};  // dscore 4, v 7: both draw

        for (int i = 0; i < 9; i++) run_hand(i);

        // Asynchronous reset while load_pcard2 is high.
        resetb = 1'b0;
        pscore = 4'd4;
        dscore = 4'd7;
        pcard3 = 4'd0;
        repeat (2) @(posedge slow_clock);
        @(negedge slow_clock);
        resetb = 1'b1;
        repeat (3) @(posedge slow_clock);
        #1;
        check("async_pre_pcard2", {7'd0, load_pcard2}, 8'd1);
        #2;
        resetb = 1'b0;
        #1;
        check("async_outputs_zero", all_outputs(), 8'd0);
        @(negedge slow_clock);
        resetb = 1'b1;
        @(posedge slow_clock);
        #1;
        check("async_restart_pcard1", all_outputs(), 8'b0000_0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
